// File: rtl/apb_cfg_slave.sv
// APB completer for the LPDDR controller config space.
// RW config registers, RO status words, fixed wait states.
module apb_cfg_slave #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_RW         = 6,
  parameter int NUM_RO         = 2,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic [APB_ADDR_WIDTH-1:0]        paddr,
  input  logic [APB_DATA_WIDTH-1:0]        pwdata,
  input  logic                             pwrite,
  input  logic                             psel,
  input  logic                             penable,
  output logic                             pready,
  output logic [APB_DATA_WIDTH-1:0]        prdata,
  output logic [NUM_RW*APB_DATA_WIDTH-1:0] cfg_regs,
  output logic [NUM_RW-1:0]                cfg_wr,
  input  logic [NUM_RO*APB_DATA_WIDTH-1:0] sts_regs
);

  localparam int W  = APB_DATA_WIDTH;
  localparam int IW = APB_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cap;
  logic [IW-1:0]     idx;
  logic [W-1:0]      rdata;
  logic [NUM_RW-1:0] wr_hit;
  logic              unused_abits;

  assign idx          = paddr[APB_ADDR_WIDTH-1:2];
  assign unused_abits = ^paddr[1:0];

  // Unmapped words fall through to zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (idx == IW'(i)) rdata = cfg_regs[i*W +: W];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (idx == IW'(NUM_RW + j)) rdata = sts_regs[j*W +: W];
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (state_q == READY && pwrite && idx == IW'(i))
        wr_hit[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && penable) begin
          cnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = READY;
            cap     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!(psel && penable)) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = READY;
          cap     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      cfg_wr  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pready  <= (state_d == READY);
      cfg_wr  <= wr_hit;
      if (cap && !pwrite) prdata <= rdata;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cfg_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_hit[i]) cfg_regs[i*W +: W] <= pwdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_cfg_slave.sv
// Scoreboard bench for apb_cfg_slave.
// Three instances cover wait-state settings 0, 3 and 4.
module tb_apb_cfg_slave;

  logic          pclk;
  logic          presetn;
  logic [15:0]   paddr;
  logic [31:0]   pwdata;
  logic          pwrite;
  logic          penable;
  logic          psel     [3];
  logic          pready   [3];
  logic [31:0]   prdata   [3];
  logic [191:0]  cfg_regs [3];
  logic [5:0]    cfg_wr   [3];
  logic [63:0]   sts;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_cfg_slave #(
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 4))
    ) u_dut (
      .pclk    (pclk),
      .presetn (presetn),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pwrite  (pwrite),
      .psel    (psel[g]),
      .penable (penable),
      .pready  (pready[g]),
      .prdata  (prdata[g]),
      .cfg_regs(cfg_regs[g]),
      .cfg_wr  (cfg_wr[g]),
      .sts_regs(sts)
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic         w;
    logic [31:0]  rd;
    logic [5:0]   wr;
    logic [191:0] regs;
    int           lat;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  logic [31:0]  mdl [3][6];
  logic [31:0]  last_rd [3];
  int           acc [3];
  logic         pend_v [3];
  logic [5:0]   pend_wr [3];
  logic [191:0] pend_regs [3];
  int           nvec = 0;
  int           nerr = 0;

  task automatic check(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wc(input int d);
    return d == 0 ? 0 : (d == 1 ? 3 : 4);
  endfunction

  function automatic logic [31:0] mread(input int d, input int idx);
    if (idx < 6) return mdl[d][idx];
    if (idx == 6) return sts[31:0];
    if (idx == 7) return sts[63:32];
    return 32'h0;
  endfunction

  function automatic logic [191:0] flat(input int d);
    logic [191:0] f;
    for (int i = 0; i < 6; i++) f[i*32 +: 32] = mdl[d][i];
    return f;
  endfunction

  task automatic clr_model();
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = '0;
      for (int i = 0; i < 6; i++) mdl[d][i] = '0;
    end
  endtask

  always @(negedge pclk) begin
    if (!presetn) begin
      for (int d = 0; d < 3; d++) begin
        acc[d]    = 0;
        pend_v[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (pend_v[d]) begin
          check("cfg_wr", cfg_wr[d], pend_wr[d]);
          check("cfg_regs", cfg_regs[d], pend_regs[d]);
          pend_v[d] = 1'b0;
        end else if (cfg_wr[d] != '0) begin
          check("cfg_wr_stray", cfg_wr[d], '0);
        end
        if (psel[d] && penable) acc[d]++;
        else acc[d] = 0;
        if (pready[d]) begin
          if (q.size() == 0) begin
            check("spurious_pready", pready[d], 1'b0);
          end else begin
            e = q.pop_front();
            check("latency", acc[d], e.lat);
            check(e.w ? "prdata_hold" : "prdata", prdata[d], e.rd);
            pend_v[d]    = 1'b1;
            pend_wr[d]   = e.wr;
            pend_regs[d] = e.regs;
          end
        end
      end
    end
  end

  task automatic xfer(input int d, input logic [15:0] a,
                      input logic [31:0] wd, input logic w);
    exp_t x;
    int   n;
    int   idx;
    idx     = int'(a[15:2]);
    psel[d] = 1'b1;
    paddr   = a;
    pwrite  = w;
    pwdata  = wd;
    penable = 1'b0;
    x.w     = w;
    x.lat   = wc(d) + 2;
    x.wr    = '0;
    if (w) begin
      if (idx < 6) begin
        mdl[d][idx] = wd;
        x.wr[idx]   = 1'b1;
      end
      x.rd = last_rd[d];
    end else begin
      x.rd       = mread(d, idx);
      last_rd[d] = x.rd;
    end
    x.regs = flat(d);
    q.push_back(x);
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready[d] && n < 40) begin
      @(negedge pclk);
      n++;
    end
    if (!pready[d]) begin
      check("timeout", n, x.lat);
      void'(q.pop_back());
    end
    @(posedge pclk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  int          rd_d;
  logic [15:0] rd_a;

  initial begin
    presetn = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pwrite  = 1'b0;
    penable = 1'b0;
    sts     = {32'hCAFEF00D, 32'h12345678};
    for (int d = 0; d < 3; d++) psel[d] = 1'b0;
    clr_model();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      check("rst_pready", pready[d], 1'b0);
      check("rst_prdata", prdata[d], '0);
      check("rst_cfg", cfg_regs[d], '0);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(1);

    for (int i = 0; i < 6; i++) xfer(0, 16'(i * 4), '0, 1'b0);
    xfer(0, 16'h08, 32'hDEADBEEF, 1'b1);
    idle(1);
    xfer(0, 16'h08, '0, 1'b0);

    xfer(1, 16'h18, '0, 1'b0);
    xfer(1, 16'h1C, '0, 1'b0);
    xfer(1, 16'h14, 32'h0BADF00D, 1'b1);
    xfer(1, 16'h14, '0, 1'b0);

    xfer(0, 16'h1C, 32'hFFFFFFFF, 1'b1);
    xfer(0, 16'h40, 32'hFFFFFFFF, 1'b1);
    xfer(0, 16'h40, '0, 1'b0);

    xfer(0, 16'h00, 32'h11111111, 1'b1);
    xfer(0, 16'h04, 32'h22222222, 1'b1);
    idle(2);
    xfer(0, 16'h00, '0, 1'b0);
    xfer(0, 16'h05, '0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      rd_d = int'($urandom_range(0, 2));
      rd_a = 16'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      xfer(rd_d, rd_a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    psel[2] = 1'b1;
    paddr   = 16'h00;
    pwrite  = 1'b1;
    pwdata  = 32'hA5A5A5A5;
    penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    presetn = 1'b0;
    q.delete();
    clr_model();
    @(negedge pclk);
    check("rst_mid_cfg", cfg_regs[2], '0);
    check("rst_mid_pready", pready[2], 1'b0);
    check("rst_mid_prdata", prdata[2], '0);
    @(posedge pclk); #1;
    psel[2] = 1'b0;
    penable = 1'b0;
    presetn = 1'b1;
    idle(1);
    xfer(2, 16'h00, 32'h00000001, 1'b1);
    xfer(2, 16'h00, '0, 1'b0);
    idle(3);

    check("queue_drained", 192'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
